// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 widths, schedule FSM states and small-sigma functions.
package sha256_pkg;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int WINDOW  = 16;
  typedef enum logic {IDLE, RUN} sched_state_t;
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sched_sigma.sv
// sched_sigma: combinational W[t+16] adder tree, kept separate so it can be pipelined later.
module sched_sigma
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] w_new
);
  assign w_new = sigma1(w14) + w9 + sigma0(w1) + w0;
endmodule

// File: rtl/msg_schedule.sv
// msg_schedule: streams SHA-256 message-schedule words from a 512-bit block through a 16-word window.
module msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int EXPAND = 1,
  parameter int IDX_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] block_in,
  input  logic               block_valid,
  output logic               block_ready,
  output logic [WORD_W-1:0]  word_out,
  output logic [IDX_W-1:0]   word_idx,
  output logic               word_last,
  output logic               word_valid,
  input  logic               word_ready
);
  localparam int N = (EXPAND != 0) ? ROUNDS : WINDOW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  sched_state_t state, state_n;
  logic [WORD_W-1:0] w [WINDOW];
  logic [WORD_W-1:0] w_new;
  logic fire, load;
  assign word_valid  = state == RUN;
  assign word_out    = w[0];
  assign word_last   = word_valid && word_idx == LAST_IDX;
  assign fire        = word_valid && word_ready;
  assign block_ready = state == IDLE || (fire && word_last);
  assign load        = block_valid && block_ready;
  sched_sigma u_sigma (
    .w0   (w[0]),
    .w1   (w[1]),
    .w9   (w[9]),
    .w14  (w[14]),
    .w_new(w_new)
  );
  always_comb state_n = load ? RUN : (fire && word_last) ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // a last-word handshake with a pending block reloads here, giving back-to-back streaming
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < WINDOW; i++) w[i] <= '0;
      word_idx <= '0;
    end else if (load) begin
      for (int i = 0; i < WINDOW; i++) w[i] <= block_in[BLOCK_W-1-WORD_W*i -: WORD_W];
      word_idx <= '0;
    end else if (fire && !word_last) begin
      for (int i = 0; i < WINDOW - 1; i++) w[i] <= w[i+1];
      w[WINDOW-1] <= (EXPAND != 0) ? w_new : '0;
      word_idx <= word_idx + 1'b1;
    end
endmodule

// File: tb/tb_msg_schedule.sv
// tb_msg_schedule: directed checks of msg_schedule in expand-64, raw-split and expand-16 configurations.
module tb_msg_schedule;
  logic clk, rst;
  logic [511:0] bi [3];
  logic bv [3];
  logic br [3];
  logic [31:0] wo [3];
  logic [5:0] wi [3];
  logic wl [3];
  logic wv [3];
  logic wr [3];
  logic [511:0] blk [2];
  logic [31:0] ref_w [2][64];
  int n_chk, n_fail;

  msg_schedule #(.ROUNDS(64), .EXPAND(1), .IDX_W(6)) u_x64 (
    .clk(clk), .rst(rst), .block_in(bi[0]), .block_valid(bv[0]), .block_ready(br[0]),
    .word_out(wo[0]), .word_idx(wi[0]), .word_last(wl[0]), .word_valid(wv[0]), .word_ready(wr[0]));
  msg_schedule #(.ROUNDS(64), .EXPAND(0), .IDX_W(6)) u_raw (
    .clk(clk), .rst(rst), .block_in(bi[1]), .block_valid(bv[1]), .block_ready(br[1]),
    .word_out(wo[1]), .word_idx(wi[1]), .word_last(wl[1]), .word_valid(wv[1]), .word_ready(wr[1]));
  msg_schedule #(.ROUNDS(16), .EXPAND(1), .IDX_W(6)) u_x16 (
    .clk(clk), .rst(rst), .block_in(bi[2]), .block_valid(bv[2]), .block_ready(br[2]),
    .word_out(wo[2]), .word_idx(wi[2]), .word_last(wl[2]), .word_valid(wv[2]), .word_ready(wr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic gen(input int k);
    for (int t = 0; t < 64; t++)
      ref_w[k][t] = (t < 16) ? blk[k][511-32*t -: 32]
                  : s1(ref_w[k][t-2]) + ref_w[k][t-7] + s0(ref_w[k][t-15]) + ref_w[k][t-16];
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_block(input int d, input int k, input int n, input bit stall);
    int cnt, guard;
    cnt = 0;
    guard = 0;
    @(negedge clk);
    bi[d] = blk[k];
    bv[d] = 1'b1;
    wr[d] = 1'b0;
    #1 check("ready_idle", 64'(br[d]), 1);
    @(negedge clk);
    bv[d] = 1'b0;
    while (cnt < n && guard < 1000) begin
      guard++;
      check("valid", 64'(wv[d]), 1);
      check("word", 64'(wo[d]), 64'(ref_w[k][cnt]));
      check("idx", 64'(wi[d]), 64'(cnt));
      check("last", 64'(wl[d]), 64'(cnt == n - 1));
      if (k == 0 && n == 64 && cnt == 17) check("w17_golden", 64'(wo[d]), 64'h000f0000);
      if (k == 0 && cnt == 15) check("w15_golden", 64'(wo[d]), 64'h00000018);
      wr[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1 check("ready_run", 64'(br[d]), 64'(wr[d] && cnt == n - 1));
      if (wr[d]) cnt++;
      @(negedge clk);
    end
    if (cnt < n) check("stream_timeout", 64'(cnt), 64'(n));
    wr[d] = 1'b0;
    check("done_valid", 64'(wv[d]), 0);
    check("done_ready", 64'(br[d]), 1);
  endtask

  initial begin
    int g;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      bi[d] = '0;
      bv[d] = 1'b0;
      wr[d] = 1'b0;
    end
    blk[0] = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) blk[1][511-32*i -: 32] = (32'h01010101 * i) ^ 32'hdeadbeef;
    gen(0);
    gen(1);
    #23;
    for (int d = 0; d < 3; d++) begin
      check("rst_valid", 64'(wv[d]), 0);
      check("rst_last", 64'(wl[d]), 0);
      check("rst_idx", 64'(wi[d]), 0);
      check("rst_word", 64'(wo[d]), 0);
      check("rst_ready", 64'(br[d]), 1);
    end
    @(negedge clk);
    rst = 1'b0;
    run_block(0, 0, 64, 1'b0);
    run_block(1, 0, 16, 1'b0);
    run_block(0, 1, 64, 1'b1);
    run_block(0, 0, 64, 1'b1);
    // back-to-back: second block held valid while the first streams
    @(negedge clk);
    bi[0] = blk[0];
    bv[0] = 1'b1;
    wr[0] = 1'b1;
    @(negedge clk);
    bi[0] = blk[1];
    for (int t = 0; t < 128; t++) begin
      check("b2b_valid", 64'(wv[0]), 1);
      check("b2b_word", 64'(wo[0]), 64'(ref_w[t/64][t%64]));
      check("b2b_idx", 64'(wi[0]), 64'(t % 64));
      check("b2b_last", 64'(wl[0]), 64'(t % 64 == 63));
      #1 check("b2b_ready", 64'(br[0]), 64'(t % 64 == 63));
      if (t == 64) bv[0] = 1'b0;
      @(negedge clk);
    end
    wr[0] = 1'b0;
    check("b2b_idle", 64'(wv[0]), 0);
    // async reset in mid-block
    bi[0] = blk[0];
    bv[0] = 1'b1;
    wr[0] = 1'b1;
    @(negedge clk);
    bv[0] = 1'b0;
    g = 0;
    while (wi[0] != 6'd30 && g < 100) begin
      g++;
      @(negedge clk);
    end
    check("pre_rst_idx", 64'(wi[0]), 30);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(wv[0]), 0);
    check("arst_word", 64'(wo[0]), 0);
    check("arst_idx", 64'(wi[0]), 0);
    check("arst_last", 64'(wl[0]), 0);
    check("arst_ready", 64'(br[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    wr[0] = 1'b0;
    run_block(0, 0, 64, 1'b0);
    run_block(2, 0, 16, 1'b1);
    run_block(1, 1, 16, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/msg_schedule.md
Name: msg_schedule

Overview:
- Parametrised successor to the 512-bit block-to-word splitter in the SHA-256 / Bitcoin hashing datapath.
- Accepts one 512-bit message block and streams message-schedule words W[0..ROUNDS-1], one per handshake, to the compression round engine.
- EXPAND=1 generates the full SHA-256 expansion (W16+ computed on the fly in a 16-word window).
- EXPAND=0 behaves as a sequenced splitter, emitting only the 16 raw words.

Parameters:
- ROUNDS, 64, words emitted per block when EXPAND=1; legal 16..64.
- EXPAND, 1, 1 = SHA-256 schedule expansion, 0 = raw split (emit exactly 16 words, ROUNDS ignored).
- IDX_W, 6, width of word_idx; must satisfy 2^IDX_W >= ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- block_in  in  512  message block; W0 = block_in[511:480], W15 = block_in[31:0] (big-endian).
- block_valid  in  1  block_in is valid.
- block_ready  out  1  block accepted when block_valid && block_ready.
- word_out  out  32  current schedule word W[word_idx].
- word_idx  out  IDX_W  index t of word_out.
- word_last  out  1  high with the final word of the block (t = N-1, where N = ROUNDS or 16).
- word_valid  out  1  word_out is valid.
- word_ready  in  1  consumer accepts the word when word_valid && word_ready.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, window regs=0, word_idx=0, word_valid=0, word_last=0, word_out=0.
- State machine has two states, IDLE and RUN.
- IDLE:
  - block_ready=1.
  - On block accept: window w[i] <= block word i for i=0..15, word_idx<=0, go to RUN.
  - word_valid rises the cycle after accept (1-cycle latency to W0).
- RUN:
  - word_valid=1, word_out=w[0], word_last=(word_idx==N-1).
  - Outputs hold stable while word_ready=0; no field may change under backpressure.
- Advance (RUN, word_valid && word_ready, not last):
  - w[i] <= w[i+1] for i=0..14, word_idx += 1.
  - w[15] <= sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], all mod 2^32.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - When EXPAND=0, w[15] <= 0 (don't-care, never emitted).
- Last word handshake:
  - If block_valid is also high that cycle, reload the window from block_in and restart at idx 0. There is no bubble, so back-to-back blocks stream continuously.
  - Otherwise go to IDLE; word_valid=0 next cycle.
- block_ready = (state==IDLE) || (word_valid && word_ready && word_last).
  - This is a combinational path from word_ready; it is documented and accepted.
- block_valid in RUN, other than the last handshake, is ignored. The producer must hold it until block_ready.
- Reset mid-block: the block is abandoned and all outputs return to reset values immediately (async).
- word_idx never wraps within a block; it returns to 0 only on reload.

Decomposition:
- Shared package sha256_pkg holds:
  - constants WORD_W=32, BLOCK_W=512, WINDOW=16;
  - sigma0/sigma1 functions, reusable by the round engine's Sigma functions.
- One natural sub-module: sched_sigma, a combinational W[t+16] adder tree (4-input mod-2^32 sum), isolated for later pipelining.
- The FSM and window stay in msg_schedule.

Test Plan:
- Test block is the "abc" padded block: 0x61626380, then 14 zero words, then 0x00000018.
  - Stream with word_ready=1 -> 64 words; W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - All 64 words match the golden C model; word_last only at idx 63.
- EXPAND=0, same block -> exactly 16 words equal to the input words in order, word_last at idx 15, then IDLE with block_ready=1.
- Random word_ready backpressure (about 50% duty) -> word_out/word_idx stable while stalled; sequence identical to the unstalled run.
- Two blocks offered back-to-back, block_valid held -> second block's W0 appears the cycle after the first block's idx-63 handshake, with no gap.
- Assert rst at idx 30 -> word_valid=0 asynchronously. After release, a new block restarts at idx 0 with correct W values.
- ROUNDS=16 with EXPAND=1 -> 16 words, last at idx 15; block_ready high only in IDLE or on the last handshake.
